// File: rtl/voice_pool_mixer_if.sv
// voice_pool_mixer_if: note events, per-voice control/status
// and the mixed sample stream of the voice pool mixer.
interface voice_pool_mixer_if #(
    parameter int NUM_VOICES = 8,
    parameter int DATA_W     = 18,
    parameter int DELAY_W    = 10
);
    logic                         note_on;
    logic                         note_off;
    logic [DELAY_W-1:0]           delay;
    logic [NUM_VOICES-1:0]        voice_prepped;
    logic [NUM_VOICES-1:0]        voice_ready;
    logic [NUM_VOICES*DATA_W-1:0] voice_data;
    logic [NUM_VOICES-1:0]        voice_go;
    logic [NUM_VOICES-1:0]        voice_release;
    logic                         ready;
    logic [DATA_W-1:0]            data_out;
    logic                         busy;
    logic                         dropped;

    modport master (
        output note_on, note_off, delay,
        output voice_prepped, voice_ready, voice_data,
        input  voice_go, voice_release,
        input  ready, data_out, busy, dropped
    );

    modport slave (
        input  note_on, note_off, delay,
        input  voice_prepped, voice_ready, voice_data,
        output voice_go, voice_release,
        output ready, data_out, busy, dropped
    );
endinterface

// File: rtl/voice_pool_mixer.sv
// voice_pool_mixer: allocates notes to voices, steals the oldest
// voice when full, and outputs a saturated registered mix.
module voice_pool_mixer #(
    parameter int NUM_VOICES    = 8,
    parameter int DATA_W        = 18,
    parameter int DELAY_W       = 10,
    parameter int AGE_W         = 12,
    parameter int STEAL_TIMEOUT = 64
) (
    input logic               clk,
    input logic               reset,
    voice_pool_mixer_if.slave bus
);
    localparam int VI_W  = $clog2(NUM_VOICES);
    localparam int SUM_W = DATA_W + $clog2(NUM_VOICES);
    localparam int CNT_W = $clog2(STEAL_TIMEOUT) + 1;

    typedef enum logic {IDLE, STEAL_WAIT} state_t;

    state_t                state_q, state_d;
    logic [NUM_VOICES-1:0] active_q, active_d;
    logic [DELAY_W-1:0]    tag_q [NUM_VOICES];
    logic [DELAY_W-1:0]    tag_d [NUM_VOICES];
    logic [AGE_W-1:0]      age_q [NUM_VOICES];
    logic [AGE_W-1:0]      age_d [NUM_VOICES];
    logic [DELAY_W-1:0]    pend_q, pend_d;
    logic [VI_W-1:0]       victim_q, victim_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [NUM_VOICES-1:0] go_q, go_d;
    logic [NUM_VOICES-1:0] rel_q, rel_d;
    logic                  dropped_q, dropped_d;
    logic                  ready_q, ready_d;
    logic [DATA_W-1:0]     data_q, data_d;

    logic [NUM_VOICES-1:0] free;
    logic                  found, has_act;
    logic [VI_W-1:0]       pick, old;
    logic [AGE_W-1:0]      best;
    logic signed [SUM_W-1:0]  sum;
    logic [SUM_W-DATA_W:0]    ext;

    // Allocator: ageing, note_off release, allocation and steal FSM
    always_comb begin
        state_d   = state_q;
        active_d  = active_q;
        tag_d     = tag_q;
        age_d     = age_q;
        pend_d    = pend_q;
        victim_d  = victim_q;
        cnt_d     = cnt_q;
        go_d      = '0;
        rel_d     = '0;
        dropped_d = 1'b0;
        found     = 1'b0;
        pick      = '0;
        has_act   = 1'b0;
        old       = '0;
        best      = '0;

        for (int i = 0; i < NUM_VOICES; i++) begin
            if (active_q[i] && age_q[i] != '1)
                age_d[i] = age_q[i] + AGE_W'(1);
        end

        if (bus.note_off) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (active_q[i] && tag_q[i] == bus.delay) begin
                    rel_d[i]    = 1'b1;
                    active_d[i] = 1'b0;
                end
            end
        end

        // A voice released this cycle must not be re-used this cycle
        free = bus.voice_prepped & ~active_d & ~rel_d;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (free[i] && !found) begin
                found = 1'b1;
                pick  = VI_W'(i);
            end
        end
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (active_d[i] && (!has_act || age_q[i] > best)) begin
                has_act = 1'b1;
                old     = VI_W'(i);
                best    = age_q[i];
            end
        end

        unique case (state_q)
            IDLE: begin
                if (bus.note_on) begin
                    if (found) begin
                        go_d[pick]     = 1'b1;
                        active_d[pick] = 1'b1;
                        tag_d[pick]    = bus.delay;
                        age_d[pick]    = '0;
                    end else if (has_act) begin
                        // Victim leaves the mix now; it returns on go
                        rel_d[old]    = 1'b1;
                        active_d[old] = 1'b0;
                        victim_d      = old;
                        pend_d        = bus.delay;
                        cnt_d         = '0;
                        state_d       = STEAL_WAIT;
                    end else begin
                        dropped_d = 1'b1;
                    end
                end
            end
            STEAL_WAIT: begin
                if (bus.note_on)
                    dropped_d = 1'b1;
                if (bus.note_off && bus.delay == pend_q) begin
                    state_d = IDLE;
                end else if (bus.voice_prepped[victim_q]) begin
                    go_d[victim_q]     = 1'b1;
                    active_d[victim_q] = 1'b1;
                    tag_d[victim_q]    = pend_q;
                    age_d[victim_q]    = '0;
                    state_d            = IDLE;
                end else if (cnt_q == CNT_W'(STEAL_TIMEOUT - 1)) begin
                    dropped_d          = 1'b1;
                    active_d[victim_q] = 1'b0;
                    state_d            = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Allocator state and control pulse registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            active_q  <= '0;
            pend_q    <= '0;
            victim_q  <= '0;
            cnt_q     <= '0;
            go_q      <= '0;
            rel_q     <= '0;
            dropped_q <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                tag_q[i] <= '0;
                age_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            active_q  <= active_d;
            pend_q    <= pend_d;
            victim_q  <= victim_d;
            cnt_q     <= cnt_d;
            go_q      <= go_d;
            rel_q     <= rel_d;
            dropped_q <= dropped_d;
            for (int i = 0; i < NUM_VOICES; i++) begin
                tag_q[i] <= tag_d[i];
                age_q[i] <= age_d[i];
            end
        end
    end

    // Mixer: widened signed sum of contributing voices, then clamp
    always_comb begin
        sum     = '0;
        ready_d = 1'b0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (bus.voice_ready[i] && active_q[i]) begin
                sum = sum + SUM_W'($signed(bus.voice_data[i*DATA_W +: DATA_W]));
                ready_d = 1'b1;
            end
        end
        ext = sum[SUM_W-1:DATA_W-1];
        if (ext == '0 || ext == '1)
            data_d = sum[DATA_W-1:0];
        else if (sum[SUM_W-1])
            data_d = {1'b1, {(DATA_W-1){1'b0}}};
        else
            data_d = {1'b0, {(DATA_W-1){1'b1}}};
    end

    // Mixer output register
    always_ff @(posedge clk) begin
        if (reset) begin
            ready_q <= 1'b0;
            data_q  <= '0;
        end else begin
            ready_q <= ready_d;
            data_q  <= data_d;
        end
    end

    assign bus.voice_go      = go_q;
    assign bus.voice_release = rel_q;
    assign bus.dropped       = dropped_q;
    assign bus.busy          = (state_q == STEAL_WAIT);
    assign bus.ready         = ready_q;
    assign bus.data_out      = data_q;
endmodule
